// File: rtl/vdp_pkg.sv
// Shared definitions for the VDP host I/O block: FSM states, command codes
// and the default register-file depth.
package vdp_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_FETCH = 2'd2,
        S_LATCH = 2'd3
    } state_t;

    localparam logic [1:0] CODE_VRD  = 2'd0;
    localparam logic [1:0] CODE_VWR  = 2'd1;
    localparam logic [1:0] CODE_REG  = 2'd2;
    localparam logic [1:0] CODE_CRAM = 2'd3;

    localparam int NUM_REGS_DEFAULT = 11;

    function automatic logic [13:0] addr_inc(input logic [13:0] a);
        return a + 14'd1;
    endfunction

endpackage

// File: rtl/vdp_io.sv
// VDP host port: two-byte control latch, VRAM read-ahead buffer, CRAM and
// register writes. Define GG_CRAM_LATCH_EN for paired 16-bit CRAM writes.
module vdp_io
    import vdp_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_wr,
    input  logic        cpu_rd,
    input  logic        cpu_port,
    input  logic [7:0]  cpu_di,
    output logic [7:0]  cpu_do,
    output logic        busy,
    output logic [13:0] vram_addr,
    output logic        vram_we,
    output logic [7:0]  vram_di,
    input  logic [7:0]  vram_do,
    output logic [5:0]  cram_addr,
    output logic        cram_we,
    output logic [15:0] cram_di,
    output logic        reg_we,
    output logic [3:0]  reg_addr,
    output logic [7:0]  reg_di,
    input  logic [7:0]  status_in,
    output logic        status_rd
);

    state_t      r_state,     w_state_next;
    logic        r_flag,      w_flag_next;
    logic [13:0] r_addr,      w_addr_next;
    logic [1:0]  r_code,      w_code_next;
    logic [7:0]  r_rbuf,      w_rbuf_next;
    logic [7:0]  r_cpu_do,    w_cpu_do_next;
    logic [13:0] r_vram_addr, w_vram_addr_next;
    logic        r_vram_we,   w_vram_we_next;
    logic [7:0]  r_vram_di,   w_vram_di_next;
    logic [5:0]  r_cram_addr, w_cram_addr_next;
    logic        r_cram_we,   w_cram_we_next;
    logic [15:0] r_cram_di,   w_cram_di_next;
    logic        r_reg_we,    w_reg_we_next;
    logic [3:0]  r_reg_addr,  w_reg_addr_next;
    logic [7:0]  r_reg_di,    w_reg_di_next;
    logic        r_status_rd, w_status_rd_next;
`ifdef GG_CRAM_LATCH_EN
    logic [7:0]  r_cram_latch, w_cram_latch_next;
`endif

    // A simultaneous read is dropped in favour of the write.
    logic w_wr;
    logic w_rd;
    logic w_reg_ok;
    assign w_wr     = cpu_wr;
    assign w_rd     = cpu_rd & ~cpu_wr;
    assign w_reg_ok = ({28'd0, cpu_di[3:0]} < 32'(NUM_REGS));

    always_comb begin
        w_state_next     = r_state;
        w_flag_next      = r_flag;
        w_addr_next      = r_addr;
        w_code_next      = r_code;
        w_rbuf_next      = r_rbuf;
        w_cpu_do_next    = r_cpu_do;
        w_vram_addr_next = r_vram_addr;
        w_vram_we_next   = 1'b0;
        w_vram_di_next   = r_vram_di;
        w_cram_addr_next = r_cram_addr;
        w_cram_we_next   = 1'b0;
        w_cram_di_next   = r_cram_di;
        w_reg_we_next    = 1'b0;
        w_reg_addr_next  = r_reg_addr;
        w_reg_di_next    = r_reg_di;
        w_status_rd_next = 1'b0;
`ifdef GG_CRAM_LATCH_EN
        w_cram_latch_next = r_cram_latch;
`endif

        case (r_state)
            S_IDLE: begin
                if (w_wr) begin
                    if (cpu_port) begin
                        if (!r_flag) begin
                            w_addr_next[7:0] = cpu_di;
                            w_flag_next      = 1'b1;
                        end else begin
                            w_flag_next       = 1'b0;
                            w_code_next       = cpu_di[7:6];
                            w_addr_next[13:8] = cpu_di[5:0];
                            if (cpu_di[7:6] == CODE_VRD) begin
                                w_state_next     = S_FETCH;
                                w_vram_addr_next = {cpu_di[5:0], r_addr[7:0]};
                            end else if (cpu_di[7:6] == CODE_REG && w_reg_ok) begin
                                w_reg_we_next   = 1'b1;
                                w_reg_addr_next = cpu_di[3:0];
                                w_reg_di_next   = r_addr[7:0];
                            end
                        end
                    end else begin
                        w_flag_next = 1'b0;
                        if (r_code != CODE_CRAM) begin
                            w_state_next     = S_WRITE;
                            w_vram_we_next   = 1'b1;
                            w_vram_addr_next = r_addr;
                            w_vram_di_next   = cpu_di;
                        end else begin
                            w_addr_next = addr_inc(r_addr);
`ifdef GG_CRAM_LATCH_EN
                            // Even byte is held until its odd partner arrives.
                            if (!r_addr[0]) begin
                                w_cram_latch_next = cpu_di;
                            end else begin
                                w_cram_we_next   = 1'b1;
                                w_cram_addr_next = {r_addr[5:1], 1'b0};
                                w_cram_di_next   = {cpu_di, r_cram_latch};
                            end
`else
                            w_cram_we_next   = 1'b1;
                            w_cram_addr_next = r_addr[5:0];
                            w_cram_di_next   = {8'h00, cpu_di};
`endif
                        end
                    end
                end else if (w_rd) begin
                    w_flag_next = 1'b0;
                    if (cpu_port) begin
                        w_cpu_do_next    = status_in;
                        w_status_rd_next = 1'b1;
                    end else begin
                        w_cpu_do_next    = r_rbuf;
                        w_state_next     = S_FETCH;
                        w_vram_addr_next = r_addr;
                    end
                end
            end
            S_WRITE: begin
                w_rbuf_next  = r_vram_di;
                w_addr_next  = addr_inc(r_addr);
                w_state_next = S_IDLE;
            end
            S_FETCH: begin
                w_state_next = S_LATCH;
            end
            S_LATCH: begin
                w_rbuf_next  = vram_do;
                w_addr_next  = addr_inc(r_addr);
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_flag      <= 1'b0;
            r_addr      <= '0;
            r_code      <= CODE_VRD;
            r_rbuf      <= '0;
            r_cpu_do    <= '0;
            r_vram_addr <= '0;
            r_vram_we   <= 1'b0;
            r_vram_di   <= '0;
            r_cram_addr <= '0;
            r_cram_we   <= 1'b0;
            r_cram_di   <= '0;
            r_reg_we    <= 1'b0;
            r_reg_addr  <= '0;
            r_reg_di    <= '0;
            r_status_rd <= 1'b0;
`ifdef GG_CRAM_LATCH_EN
            r_cram_latch <= '0;
`endif
        end else begin
            r_state     <= w_state_next;
            r_flag      <= w_flag_next;
            r_addr      <= w_addr_next;
            r_code      <= w_code_next;
            r_rbuf      <= w_rbuf_next;
            r_cpu_do    <= w_cpu_do_next;
            r_vram_addr <= w_vram_addr_next;
            r_vram_we   <= w_vram_we_next;
            r_vram_di   <= w_vram_di_next;
            r_cram_addr <= w_cram_addr_next;
            r_cram_we   <= w_cram_we_next;
            r_cram_di   <= w_cram_di_next;
            r_reg_we    <= w_reg_we_next;
            r_reg_addr  <= w_reg_addr_next;
            r_reg_di    <= w_reg_di_next;
            r_status_rd <= w_status_rd_next;
`ifdef GG_CRAM_LATCH_EN
            r_cram_latch <= w_cram_latch_next;
`endif
        end
    end

    assign cpu_do    = r_cpu_do;
    assign busy      = (r_state != S_IDLE);
    assign vram_addr = r_vram_addr;
    assign vram_we   = r_vram_we;
    assign vram_di   = r_vram_di;
    assign cram_addr = r_cram_addr;
    assign cram_we   = r_cram_we;
    assign cram_di   = r_cram_di;
    assign reg_we    = r_reg_we;
    assign reg_addr  = r_reg_addr;
    assign reg_di    = r_reg_di;
    assign status_rd = r_status_rd;

endmodule
